dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported data memory (addr / w_data / r_data / mem_w / mem_r) between the CPU datapath (port 0) and a loader/debug master (port 1).
- Port 0 has fixed priority, with a starvation guard for port 1.
- Supports a lock for read-modify-write sequences.
- Registers read data back to the owning requester.

---
 rtl/dmem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU (port 0) and a loader/debug master (port 1).
// Latency: grant is combinational and the access completes at that edge; read data returns registered one cycle later.
// Backpressure: a requester holds req until gnt; port 0 wins ties except after MAX_BURST consecutive wins over a waiting port 1.
//
// Ports:
//   clk, rst_n                     clock (rising edge) and asynchronous active-low reset
//   reqN, weN, lockN, addrN, wdataN   request side of port N (N = 0 CPU, 1 loader/debug)
//   gntN                            combinational grant; the access is taken at this clock edge
//   rvalidN, rdataN                 registered read-return strobe and data, one cycle after a read grant
//   mem_addr, mem_w_data, mem_w, mem_r  memory command (all zero when nobody is granted)
//   mem_r_data                      combinational read data from the memory
//   err0, err1                      only with DMEM_ARB_ALIGN_CHK_EN: one-cycle pulse after a misaligned access
//
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN (misaligned-access suppression and err0/err1 outputs).

module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  // port 0: CPU datapath
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,

  // port 1: loader / debug master
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

`ifdef DMEM_ARB_ALIGN_CHK_EN
  output logic              err0,
  output logic              err1,
`endif

  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              mem_w,
  output logic              mem_r
);

  // Counter must be able to hold MAX_BURST itself (saturation value).
  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // Misaligned-access flags; tied low when the alignment check is compiled out.
  logic             mis0;
  logic             mis1;

  // Per-port "read taken this cycle" terms shared by the return path.
  logic             rd_take0;
  logic             rd_take1;

  assign starved = (starve_cnt == MAX_CNT);

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign mis0 = (addr0[1:0] != 2'b00);
  assign mis1 = (addr1[1:0] != 2'b00);
`else
  assign mis0 = 1'b0;
  assign mis1 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant decision.
  // Grants are gated by rst_n so that an asserted reset silences the memory
  // command in the same cycle, not just at the next edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        LOCK0: gnt0 = req0;
        LOCK1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            // Port 1 only wins a tie once port 0 has used up its burst.
            gnt1 = starved;
            gnt0 = ~starved;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command mux. A misaligned access is still consumed (gnt high) but
  // never reaches the memory as a read or write.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr   = '0;
    mem_w_data = '0;
    mem_w      = 1'b0;
    mem_r      = 1'b0;
    if (gnt0) begin
      mem_addr   = addr0;
      mem_w_data = wdata0;
      mem_w      = we0 & ~mis0;
      mem_r      = ~we0 & ~mis0;
    end else if (gnt1) begin
      mem_addr   = addr1;
      mem_w_data = wdata1;
      mem_w      = we1 & ~mis1;
      mem_r      = ~we1 & ~mis1;
    end
  end

  // ---------------------------------------------------------------------------
  // Ownership state and starvation counter.
  // In a lock state the counter is frozen: the locked sequence is atomic and
  // does not count as port 0 bursting past a waiting port 1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (gnt1 || !req1) begin
            starve_cnt <= '0;
          end else if (gnt0 && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end

          if (gnt0 && lock0) begin
            state <= LOCK0;
          end else if (gnt1 && lock1) begin
            state <= LOCK1;
          end
        end
        // While locked, gntN equals reqN, so "granted with lock low" and
        // "request dropped" together cover every exit.
        LOCK0: begin
          if (!req0 || !lock0) begin
            state <= ARB;
          end
        end
        LOCK1: begin
          if (!req1 || !lock1) begin
            state <= ARB;
          end
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return. rdataN only updates on its own read, so it keeps the last
  // value returned to that port between reads.
  // ---------------------------------------------------------------------------
  assign rd_take0 = gnt0 & ~we0;
  assign rd_take1 = gnt1 & ~we1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rd_take0;
      rvalid1 <= rd_take1;
      // A misaligned read still returns a strobe, carrying zero data.
      if (rd_take0) begin
        rdata0 <= mis0 ? '0 : mem_r_data;
      end
      if (rd_take1) begin
        rdata1 <= mis1 ? '0 : mem_r_data;
      end
    end
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  // Error pulse lines up with the would-be read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= gnt0 & mis0;
      err1 <= gnt1 & mis1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by random traffic on both ports, checked against a reference model.
// Latency: expected read data is queued at the grant and must come back exactly one cycle later.
// Backpressure: each port holds its request until the reference model says it was granted.

module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_w_data, mem_r_data;
  logic          mem_w, mem_r;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic          err0, err1;
  bit            exp_er0, exp_er1;
`endif

  // phys_mem is the memory the DUT talks to; ref_mem is the model's view.
  logic [DW-1:0] phys_mem [64];
  logic [DW-1:0] ref_mem  [64];

  typedef struct {
    int            due;
    logic [DW-1:0] dat;
  } rd_exp_t;

  rd_exp_t q0[$];
  rd_exp_t q1[$];

  int       n_vec = 0;
  int       n_err = 0;
  int       cyc   = 0;

  // reference model state: owner -1 = nobody, else locked port
  int       owner;
  int       wins;          // consecutive port-0 wins while port 1 waited
  bit       exp_rv0, exp_rv1;
  bit       last_g0, last_g1;
  logic [9:0] gseq;

  always #5 clk = ~clk;

  function automatic logic [5:0] widx(input logic [AW-1:0] a);
    return 6'((a >> 2) & 32'h3F);
  endfunction

  function automatic bit misaligned(input logic [AW-1:0] a);
    return ALIGN_EN && (a[1:0] != 2'b00);
  endfunction

  assign mem_r_data = phys_mem[widx(mem_addr)];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .we0        (we0),
    .lock0      (lock0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .gnt0       (gnt0),
    .rvalid0    (rvalid0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .lock1      (lock1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .gnt1       (gnt1),
    .rvalid1    (rvalid1),
    .rdata1     (rdata1),
`ifdef DMEM_ARB_ALIGN_CHK_EN
    .err0       (err0),
    .err1       (err1),
`endif
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .mem_w      (mem_w),
    .mem_r      (mem_r)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    owner   = -1;
    wins    = 0;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    exp_er0 = 1'b0;
    exp_er1 = 1'b0;
`endif
    q0.delete();
    q1.delete();
  endtask

  // Called at the falling edge: compares this cycle's combinational outputs,
  // then advances the model to the next cycle.
  task automatic check_model();
    bit            g0, g1, mis, any;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_exp_t       e;

    chk("rvalid0", rvalid0, exp_rv0);
    chk("rvalid1", rvalid1, exp_rv1);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    chk("err0", err0, exp_er0);
    chk("err1", err1, exp_er1);
`endif
    gseq = {gseq[8:0], gnt1};

    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      if (owner == 0)            g0 = req0;
      else if (owner == 1)       g1 = req1;
      else if (req0 && req1) begin
        if (wins >= MB) g1 = 1'b1;
        else            g0 = 1'b1;
      end else begin
        g0 = req0;
        g1 = req1;
      end
    end
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);

    any = g0 || g1;
    we  = g0 ? we0 : we1;
    a   = g0 ? addr0 : addr1;
    d   = g0 ? wdata0 : wdata1;
    mis = any && misaligned(a);
    chk("mem_w", mem_w, any && we && !mis);
    chk("mem_r", mem_r, any && !we && !mis);
    chk("mem_addr", mem_addr, any ? a : '0);
    chk("mem_w_data", mem_w_data, any ? d : '0);

    if (!rst_n) begin
      model_reset();
    end else begin
      exp_rv0 = g0 && !we;
      exp_rv1 = g1 && !we;
`ifdef DMEM_ARB_ALIGN_CHK_EN
      exp_er0 = g0 && mis;
      exp_er1 = g1 && mis;
`endif
      if (any && !we) begin
        e.due = cyc + 1;
        e.dat = mis ? '0 : ref_mem[widx(a)];
        if (g0) q0.push_back(e);
        else    q1.push_back(e);
      end
      if (any && we && !mis) ref_mem[widx(a)] = d;

      if (owner < 0) begin
        if (g1 || !req1)         wins = 0;
        else if (g0 && wins < MB) wins++;
        if (g0 && lock0)      owner = 0;
        else if (g1 && lock1) owner = 1;
      end else if (owner == 0) begin
        if (!req0 || !lock0) owner = -1;
      end else begin
        if (!req1 || !lock1) owner = -1;
      end
    end
    last_g0 = g0;
    last_g1 = g1;
  endtask

  // Read-return monitor: pops the scoreboard whenever a port presents rvalid.
  task automatic mon();
    rd_exp_t e;
    if (rvalid0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        chk("rdata0", rdata0, e.dat);
      end else begin
        n_vec++; n_err++;
        $display("FAIL rvalid0_unexpected cyc=%0d got=1 expected=0", cyc);
      end
    end else if (q0.size() > 0 && q0[0].due <= cyc) begin
      void'(q0.pop_front());
      n_vec++; n_err++;
      $display("FAIL rvalid0_missing cyc=%0d got=0 expected=1", cyc);
    end
    if (rvalid1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        chk("rdata1", rdata1, e.dat);
      end else begin
        n_vec++; n_err++;
        $display("FAIL rvalid1_unexpected cyc=%0d got=1 expected=0", cyc);
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      void'(q1.pop_front());
      n_vec++; n_err++;
      $display("FAIL rvalid1_missing cyc=%0d got=0 expected=1", cyc);
    end
  endtask

  // One clock: check at the falling edge, optionally reset just after the
  // check, then apply the memory write at the rising edge.
  task automatic step(input bit rst_mid);
    logic          sw;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    @(negedge clk);
    check_model();
    sw = mem_w;
    sa = mem_addr;
    sd = mem_w_data;
    if (rst_mid) begin
      #2;
      rst_n = 1'b0;
      model_reset();
    end
    @(posedge clk);
    if (sw && rst_n) phys_mem[widx(sa)] = sd;
    #1;
  endtask

  task automatic set0(input bit r, input bit w, input bit l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input bit r, input bit w, input bit l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  // Present a port-1 request and hold it until granted (bounded).
  task automatic issue1(input bit w, input bit l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    set1(1'b1, w, l, a, d);
    for (int k = 0; k < 12; k++) begin
      step(1'b0);
      if (last_g1) begin
        got = 1'b1;
        break;
      end
    end
    chk("issue1_granted", got, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    rst_n = 1'b0;
    gseq  = '0;
    set0(1'b0, 1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    last_g0 = 1'b0;
    last_g1 = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon();
      end
      forever begin
        @(posedge clk);
        cyc++;
      end
    join_none

    // reset state
    step(1'b0);
    step(1'b0);
    chk("rst_rdata0", rdata0, '0);
    chk("rst_rdata1", rdata1, '0);
    rst_n = 1'b1;

    // write then read back on port 0
    set0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    step(1'b0);
    set0(1'b1, 1'b0, 1'b0, 32'h10, '0);
    step(1'b0);
    set0(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0);

    // mid-cycle reset while a read return is on the outputs
    set0(1'b1, 1'b0, 1'b0, 32'h10, '0);
    step(1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_now_gnt0", gnt0, 1'b0);
    chk("rst_now_rvalid0", rvalid0, 1'b0);
    chk("rst_now_mem_r", mem_r, 1'b0);
    chk("rst_now_mem_w", mem_w, 1'b0);
    chk("rst_now_rdata0", rdata0, '0);
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    set0(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0);

    // both ports requesting continuously: starvation guard cadence
    set0(1'b1, 1'b0, 1'b0, 32'h0, '0);
    set1(1'b1, 1'b0, 1'b0, 32'h4, '0);
    for (int k = 0; k < 10; k++) step(1'b0);
    chk("burst_seq", gseq, 10'b0000100001);
    set0(1'b0, 1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0);
    step(1'b0);

    // locked read-modify-write on port 1 against a persistent port 0
    set0(1'b1, 1'b0, 1'b0, 32'h30, '0);
    issue1(1'b0, 1'b1, 32'h20, '0);
    issue1(1'b1, 1'b0, 32'h20, 32'hA5A5_0F0F);
    set1(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0);
    chk("post_lock_gnt0", last_g0, 1'b1);
    set0(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0);

    // reset inside LOCK1 with a read just granted
    issue1(1'b0, 1'b1, 32'h24, '0);
    set1(1'b1, 1'b0, 1'b1, 32'h28, '0);
    step(1'b1);
    set1(1'b0, 1'b0, 1'b0, '0, '0);
    set0(1'b1, 1'b0, 1'b0, 32'h10, '0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    set0(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0);

`ifdef DMEM_ARB_ALIGN_CHK_EN
    // misaligned write is swallowed; the aligned word stays intact
    set0(1'b1, 1'b1, 1'b0, 32'h13, 32'h1234_5678);
    step(1'b0);
    set0(1'b1, 1'b0, 1'b0, 32'h10, '0);
    step(1'b0);
    set0(1'b1, 1'b0, 1'b0, 32'h17, '0);
    step(1'b0);
    set0(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0);
    step(1'b0);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!req0 || last_g0) begin
        if ($urandom_range(0, 3) != 0)
          set0(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               AW'($urandom_range(0, 63)) << 2, $urandom);
        else
          set0(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (!req1 || last_g1) begin
        if ($urandom_range(0, 2) == 0)
          set1(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               AW'($urandom_range(0, 63)) << 2, $urandom);
        else
          set1(1'b0, 1'b0, 1'b0, '0, '0);
      end
      step(1'b0);
    end

    set0(1'b0, 1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) step(1'b0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
